// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing one register-file write port
// among NREQ write-back requesters, with a single registered output stage.
// Optional feature: define RF_WB_BYPASS_EN to add a same-cycle read bypass
// of the write currently presented on the register-file port.
//
// Handshake: a requester holds req_valid/addr/data stable until it sees
// req_ready; a transfer happens in any cycle where req_valid[i] & req_ready[i].
// req_ready depends only on req_valid, rr_ptr, hold, flush and rst, never on
// the requester's address or data.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  input  logic              flush,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [2:0]        grant_idx,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0]     byp_raddr1,
  input  logic [AW-1:0]     byp_raddr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DW-1:0]     byp_data1,
  output logic [DW-1:0]     byp_data2,
`endif
  output logic              busy
);

  // Round-robin pointer: the requester searched first in the current cycle.
  logic [2:0]    rr_ptr;

  // Registered write stage presented to the register file.
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  // Arbitration results.
  logic          found_hi;
  logic          found_lo;
  logic [2:0]    sel_hi;
  logic [2:0]    sel_lo;
  logic [2:0]    gnt_sel;
  logic          allow;
  logic          granted;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [2:0]    ptr_next;

  // Two-pass search: first valid requester at or above rr_ptr, otherwise
  // the lowest valid requester overall (that is the wrap-around part).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_hi && req_valid[i] && (3'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        sel_hi   = 3'(i);
      end
      if (!found_lo && req_valid[i]) begin
        found_lo = 1'b1;
        sel_lo   = 3'(i);
      end
    end
    gnt_sel = found_hi ? sel_hi : sel_lo;
  end

  // Grant qualification and the handshake-facing outputs.
  always_comb begin
    allow     = ~rst & ~hold & ~flush;
    granted   = found_lo & allow;
    req_ready = '0;
    grant_idx = '0;
    if (granted) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_sel;
      grant_idx = gnt_sel;
    end
    busy = (|req_valid) & ~granted & ~rst;
  end

  // Route the granted requester's address and data toward the stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_sel == 3'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Pointer moves just past the granted requester, wrapping at NREQ-1.
  always_comb begin
    ptr_next = rr_ptr;
    if (granted) begin
      ptr_next = (gnt_sel == 3'(NREQ-1)) ? 3'd0 : gnt_sel + 3'd1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= ptr_next;
    end
  end

  // Output stage: load on transfer; x0 writes are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (granted) begin
      we_q    <= (sel_addr != '0);
      waddr_q <= sel_addr;
      wdata_q <= sel_data;
    end else begin
      we_q    <= 1'b0;
    end
  end

  // A flush kills the write being presented in the flush cycle itself.
  always_comb begin
    rf_we    = we_q & ~flush;
    rf_waddr = waddr_q;
    rf_wdata = wdata_q;
  end

`ifdef RF_WB_BYPASS_EN
  // Same-cycle bypass of the landing write; rf_we already excludes x0 and flush.
  always_comb begin
    byp_hit1  = rf_we & (byp_raddr1 == waddr_q);
    byp_hit2  = rf_we & (byp_raddr2 == waddr_q);
    byp_data1 = wdata_q;
    byp_data2 = wdata_q;
  end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (address, data, write-enable) among NREQ write-back requesters, e.g. ALU, load unit and CSR unit.
- Round-robin arbitration with per-requester valid/ready handshake.
- One registered output stage drives the register-file write port; a flush cancels the pending write.
- Sits between execute/memory write-back sources and the register file.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  bit i: requester i has a write pending.
- req_addr  in  NREQ*AW  requester i destination address, bits [i*AW +: AW].
- req_data  in  NREQ*DW  requester i write data, bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot or zero; bit i: requester i accepted this cycle.
- hold  in  1  when 1, accept nothing (all req_ready=0); the pending stage still drains.
- flush  in  1  kills the write registered last cycle and blocks acceptance this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  DW  register-file write data.
- grant_idx  out  3  index of the requester accepted this cycle (valid when |req_ready).
- busy  out  1  1 when any req_valid is high and no grant was issued this cycle.

Behaviour:
- Reset (rst=1 at the edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer rr_ptr=0.
  - While rst is high: req_ready=0, grant_idx=0, busy=0.
- Grant (combinational, same cycle):
  - Search starts at rr_ptr, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - The first i with req_valid[i]=1 is granted, req_ready[i]=1.
  - No grant when hold=1, flush=1 or rst=1.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - A requester keeps valid, addr and data stable until ready.
  - Ready never depends on the requester's own data.
- Pointer update:
  - On transfer, rr_ptr <= (granted index + 1) mod NREQ.
  - Otherwise rr_ptr holds. Wrap from NREQ-1 goes to 0.
- Output stage, latency 1:
  - On transfer: rf_waddr <= addr, rf_wdata <= data, rf_we <= (addr != 0).
  - With no transfer: rf_we <= 0; rf_waddr and rf_wdata hold their previous values.
  - The register file consumes the write every cycle, so the stage never back-pressures. Throughput is one write per cycle.
- Address 0 writes:
  - Accepted (ready=1, pointer advances) but rf_we stays 0; x0 is never written.
- Flush:
  - flush=1 forces rf_we <= 0 at the next edge.
  - The write registered in the current cycle was already presented; the kill applies to the stage value presented during the flush cycle (rf_we combinationally gated by ~flush).
  - No new acceptance during the flush cycle.
- Hold and flush together: behaves as flush.
- Reset mid-operation:
  - The pending write is dropped (rf_we=0 the cycle after rst).
  - Requesters must re-present; no partial state survives.
- Fairness:
  - With all NREQ valid continuously, each requester is granted exactly once in every NREQ consecutive grant cycles.
  - Maximum wait for a valid requester without hold or flush is NREQ-1 cycles.
- busy=1 if |req_valid & ~|req_ready & ~rst. It is used by the pipeline controller to stall.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds inputs byp_raddr1, byp_raddr2 (AW each).
  - Adds outputs byp_hit1, byp_hit2 (1) and byp_data1, byp_data2 (DW).
  - byp_hitN = rf_we & ~flush & (byp_raddrN == rf_waddr); byp_dataN = rf_wdata. All combinational, 0 latency.
  - Lets readers see the write landing this cycle before the register file updates.
  - Address 0 never hits.
- Not defined: these ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=3'b111 held for 6 cycles:
  - grant sequence 0,1,2,0,1,2.
  - rf_waddr follows one cycle later.
  - rf_we=1 each cycle for nonzero addresses.
- Single requester 1 valid, addr=5, data=32'h00000025:
  - req_ready=3'b010 the same cycle.
  - Next cycle rf_we=1, rf_waddr=5, rf_wdata=32'h25.
  - Then rf_we=0.
- Requester 0 addr=0, data=32'hDEADBEEF: ready=1, next cycle rf_we=0, rr_ptr=1.
- hold=1 with all valid for 3 cycles: req_ready=0, busy=1, rr_ptr unchanged. Releasing hold grants the rr_ptr requester first.
- Accept addr=9, then flush=1 in the following cycle: rf_we observed 0, no new grant that cycle. With RF_WB_BYPASS_EN, byp_hit1=0 for raddr=9.
- rst asserted while requester 2 is being accepted: rf_we=0 next cycle and rr_ptr=0. After release, requester 2 is re-granted after requesters 0 and 1 if they are valid.
